// File: rtl/mixer_scheduler.sv
// mixer_scheduler: round-robin arbiter that time-shares one combinational
// mixer among NCH channels. Stage A holds the granted channel's operands
// in front of the mixer. Stage B holds the captured mixer result until the
// downstream modulator accepts it.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where the producer's valid/request and the consumer's ready/grant are
// both 1. A producer holds its data stable until that edge. The consumer
// may drop ready/grant at any time.
module mixer_scheduler #(
  parameter int NCH = 4,
  parameter int W   = 20,
  parameter int CW  = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [NCH-1:0]   req_i,
  input  logic [NCH*W-1:0] sample_i,
  input  logic [NCH*W-1:0] lo_i,
  output logic [NCH-1:0]   gnt_o,
  output logic [W-1:0]     mix_interp_o,
  output logic [W-1:0]     mix_lo_o,
  input  logic [W-1:0]     mix_result_i,
  output logic             res_valid_o,
  output logic [CW-1:0]    res_ch_o,
  output logic [W-1:0]     res_data_o,
  input  logic             res_ready_i,
  output logic             busy_o
);

  // Stage A: operands presented to the mixer
  logic          r_op_valid;
  logic [CW-1:0] r_op_ch;
  logic [W-1:0]  r_op_sample;
  logic [W-1:0]  r_op_lo;
  // Stage B: captured result
  logic          r_res_valid;
  logic [CW-1:0] r_res_ch;
  logic [W-1:0]  r_res_data;
  // Round-robin pointer: channel with highest priority on the next scan
  logic [CW-1:0] r_ptr;

  logic          w_b_free;
  logic          w_a_adv;
  logic          w_a_load;
  logic          w_grant;
  logic [CW-1:0] w_gnt_ch;
  logic [CW:0]   w_idx;
  logic [NCH-1:0] w_gnt;
  logic [CW-1:0] w_ptr_nxt;

  assign w_b_free = !r_res_valid || res_ready_i;
  assign w_a_adv  = r_op_valid && w_b_free;
  assign w_a_load = !r_op_valid || w_a_adv;

  // Scan requests starting at r_ptr, wrapping modulo NCH; first hit wins.
  // Gated by reset_n so no grant is ever shown while reset is held.
  always_comb begin
    w_grant  = 1'b0;
    w_gnt_ch = '0;
    w_idx    = '0;
    w_gnt    = '0;
    if (reset_n && en_i && w_a_load) begin
      for (int i = 0; i < NCH; i++) begin
        w_idx = {1'b0, r_ptr} + (CW+1)'(i);
        if (w_idx >= (CW+1)'(NCH)) w_idx = w_idx - (CW+1)'(NCH);
        if (!w_grant && req_i[w_idx[CW-1:0]]) begin
          w_grant  = 1'b1;
          w_gnt_ch = w_idx[CW-1:0];
        end
      end
    end
    if (w_grant) w_gnt[w_gnt_ch] = 1'b1;
  end

  // Next pointer: the channel after the one just granted, wrapping at NCH
  always_comb begin
    w_ptr_nxt = w_gnt_ch + 1'b1;
    if (w_gnt_ch == CW'(NCH-1)) w_ptr_nxt = '0;
  end

  // Stage A load/drain and pointer update. Operands are cleared on drain so
  // the mixer sees zero whenever stage A is empty.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_op_valid  <= 1'b0;
      r_op_ch     <= '0;
      r_op_sample <= '0;
      r_op_lo     <= '0;
      r_ptr       <= '0;
    end else if (w_grant) begin
      r_op_valid  <= 1'b1;
      r_op_ch     <= w_gnt_ch;
      r_op_sample <= sample_i[w_gnt_ch*W +: W];
      r_op_lo     <= lo_i[w_gnt_ch*W +: W];
      r_ptr       <= w_ptr_nxt;
    end else if (w_a_adv) begin
      r_op_valid  <= 1'b0;
      r_op_ch     <= '0;
      r_op_sample <= '0;
      r_op_lo     <= '0;
    end
  end

  // Stage B capture on A advance; otherwise clear valid once consumed
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_data  <= '0;
    end else if (w_a_adv) begin
      r_res_valid <= 1'b1;
      r_res_ch    <= r_op_ch;
      r_res_data  <= mix_result_i;
    end else if (r_res_valid && res_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end

  assign gnt_o        = w_gnt;
  assign mix_interp_o = r_op_sample;
  assign mix_lo_o     = r_op_lo;
  assign res_valid_o  = r_res_valid;
  assign res_ch_o     = r_res_ch;
  assign res_data_o   = r_res_data;
  assign busy_o       = r_op_valid || r_res_valid;

endmodule

// File: tb/tb_mixer_scheduler.sv
// Directed bench for mixer_scheduler with a behavioural mixer model:
// mix_o = (interp * lo) >> 14, truncated to W bits.
module tb_mixer_scheduler;
  localparam int NCH = 4;
  localparam int W   = 20;
  localparam int CW  = 2;

  // clock/reset block
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic             en_i;
  logic [NCH-1:0]   req_i;
  logic [NCH*W-1:0] sample_i;
  logic [NCH*W-1:0] lo_i;
  logic [NCH-1:0]   gnt_o;
  logic [W-1:0]     mix_interp_o;
  logic [W-1:0]     mix_lo_o;
  logic [W-1:0]     mix_result_i;
  logic             res_valid_o;
  logic [CW-1:0]    res_ch_o;
  logic [W-1:0]     res_data_o;
  logic             res_ready_i;
  logic             busy_o;

  logic [2*W-1:0] prod;
  assign prod = {{W{1'b0}}, mix_interp_o} * {{W{1'b0}}, mix_lo_o};
  assign mix_result_i = prod[W+13:14];

  mixer_scheduler #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .en_i         (en_i),
    .req_i        (req_i),
    .sample_i     (sample_i),
    .lo_i         (lo_i),
    .gnt_o        (gnt_o),
    .mix_interp_o (mix_interp_o),
    .mix_lo_o     (mix_lo_o),
    .mix_result_i (mix_result_i),
    .res_valid_o  (res_valid_o),
    .res_ch_o     (res_ch_o),
    .res_data_o   (res_data_o),
    .res_ready_i  (res_ready_i),
    .busy_o       (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Round-robin data set: sample_k = 0x4000*(k+1), lo_k = 16+k,
  // so result_k = (k+1)*(16+k): 16, 34, 54, 76.
  logic [W-1:0] rr_exp[NCH] = '{20'd16, 20'd34, 20'd54, 20'd76};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] s, input logic [W-1:0] l);
    sample_i[k*W +: W] = s;
    lo_i[k*W +: W]     = l;
  endtask

  task automatic set_rr_data();
    for (int k = 0; k < NCH; k++) set_ch(k, W'(32'h4000 * (k + 1)), W'(16 + k));
  endtask

  initial begin
    reset_n     = 1'b0;
    en_i        = 1'b1;
    req_i       = 4'b1111;
    res_ready_i = 1'b1;
    sample_i    = '0;
    lo_i        = '0;
    set_rr_data();

    // Reset held 3 cycles with every channel requesting
    step(); step(); step();
    check("rst_gnt",   gnt_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_interp", mix_interp_o, 0);
    check("rst_lo",    mix_lo_o, 0);
    check("rst_busy",  busy_o, 0);
    reset_n = 1'b1;
    #1;
    check("rel_gnt_ch0", gnt_o, 4'b0001);
    step();
    req_i = '0;
    step(); step();
    check("rel_drain_busy", busy_o, 0);

    // Single request on ch2 (ptr is 1 here)
    set_ch(2, 20'h04000, 20'h04000);
    req_i = 4'b0100;
    #1;
    check("single_gnt", gnt_o, 4'b0100);
    step();
    req_i = '0;
    #1;
    check("single_gnt_once", gnt_o, 0);
    check("single_not_yet", res_valid_o, 0);
    check("single_op_interp", mix_interp_o, 20'h04000);
    step();
    check("single_valid", res_valid_o, 1);
    check("single_ch", res_ch_o, 2);
    check("single_data", res_data_o, 20'h04000);
    check("single_op_zero", mix_interp_o, 0);
    check("single_lo_zero", mix_lo_o, 0);
    step();
    check("single_done", res_valid_o, 0);
    check("single_idle", busy_o, 0);

    // Round robin from ptr 0 with all channels requesting
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set_rr_data();
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_gnt", gnt_o, 32'(1) << (i % NCH));
      step();
      if (i >= 1) begin
        check("rr_valid", res_valid_o, 1);
        check("rr_ch", res_ch_o, (i - 1) % NCH);
        check("rr_data", res_data_o, rr_exp[(i - 1) % NCH]);
      end
    end
    req_i = '0;
    step();
    check("rr_last_ch", res_ch_o, 3);
    check("rr_last_data", res_data_o, rr_exp[3]);
    step();
    check("rr_empty", res_valid_o, 0);

    // Backpressure on ch1: results 1, 3, 5 in order, none lost or repeated
    set_ch(1, 20'd100, 20'd300);
    req_i = 4'b0010;
    #1;
    check("bp_gnt1", gnt_o, 4'b0010);
    step();
    set_ch(1, 20'd200, 20'd300);
    #1;
    check("bp_gnt2", gnt_o, 4'b0010);
    step();
    set_ch(1, 20'd300, 20'd300);
    res_ready_i = 1'b0;
    #1;
    check("bp_first_data", res_data_o, 1);
    check("bp_gnt_blocked", gnt_o, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_hold_valid", res_valid_o, 1);
      check("bp_hold_data", res_data_o, 1);
      check("bp_hold_ch", res_ch_o, 1);
      check("bp_hold_op", mix_interp_o, 20'd200);
      check("bp_hold_gnt", gnt_o, 0);
    end
    res_ready_i = 1'b1;
    #1;
    check("bp_resume_gnt", gnt_o, 4'b0010);
    step();
    req_i = '0;
    check("bp_second_data", res_data_o, 3);
    check("bp_second_ch", res_ch_o, 1);
    step();
    check("bp_third_data", res_data_o, 5);
    check("bp_third_valid", res_valid_o, 1);
    step();
    check("bp_empty", res_valid_o, 0);
    check("bp_idle", busy_o, 0);

    // en_i dropped with A and B full (ptr is 2)
    set_rr_data();
    req_i = 4'b1111;
    step();
    step();
    en_i = 1'b0;
    #1;
    check("en_gnt_off", gnt_o, 0);
    check("en_busy", busy_o, 1);
    check("en_b_ch", res_ch_o, 2);
    check("en_b_data", res_data_o, rr_exp[2]);
    step();
    check("en_drain_ch", res_ch_o, 3);
    check("en_drain_data", res_data_o, rr_exp[3]);
    check("en_drain_gnt", gnt_o, 0);
    step();
    check("en_empty", res_valid_o, 0);
    check("en_idle", busy_o, 0);
    check("en_still_off", gnt_o, 0);

    // Reset pulsed with A and B full (ptr is 0)
    en_i = 1'b1;
    step();
    step();
    res_ready_i = 1'b0;
    step();
    check("rm_b_held", res_ch_o, 0);
    check("rm_gnt_blocked", gnt_o, 0);
    reset_n = 1'b0;
    step();
    reset_n     = 1'b1;
    res_ready_i = 1'b1;
    #1;
    check("rm_no_result", res_valid_o, 0);
    check("rm_idle", busy_o, 0);
    check("rm_op_zero", mix_interp_o, 0);
    check("rm_ptr0", gnt_o, 4'b0001);
    req_i = '0;
    step();
    check("rm_no_result2", res_valid_o, 0);

    // Wrap and skip: move ptr to 3 through a lone ch2 grant
    req_i = 4'b0100;
    step();
    req_i = '0;
    step(); step();
    req_i = 4'b1010;
    #1;
    check("wrap_gnt_ch3", gnt_o, 4'b1000);
    step();
    check("wrap_gnt_ch1", gnt_o, 4'b0010);
    step();
    check("wrap_res_ch3", res_ch_o, 3);
    check("wrap_res_d3", res_data_o, rr_exp[3]);
    check("skip_gnt_ch3", gnt_o, 4'b1000);
    step();
    check("wrap_res_ch1", res_ch_o, 1);
    check("wrap_res_d1", res_data_o, rr_exp[1]);
    req_i = '0;
    #1;
    check("skip_gnt_none", gnt_o, 0);
    step();
    check("skip_res_ch3", res_ch_o, 3);
    check("skip_res_valid", res_valid_o, 1);
    step();
    check("skip_no_extra", res_valid_o, 0);
    step();
    check("skip_no_extra2", res_valid_o, 0);
    check("skip_idle", busy_o, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mixer_scheduler.md
# mixer_scheduler

Round-robin scheduler that time-shares one combinational MIXER instance among NCH requesting channels of the delta-sigma datapath. Each channel presents an interpolated sample and its LO word. The scheduler grants one channel per cycle, registers the operands onto the mixer inputs and captures the mixer output. It returns the result with a channel tag over a valid/ready handshake, and sits between the per-channel interpolators and the per-channel modulators.

## Interface
- NCH, default 4: number of requesting channels, 2..8.
- W, default 20: sample, LO and result width.
- CW, default 2: channel-tag width; must equal ceil(log2(NCH)).
- clock  in  1  rising-edge clock; all state updates on this edge.
- reset_n  in  1  synchronous, active-low reset.
- en_i  in  1  when low, no new grants; in-flight work drains.
- req_i  in  NCH  per-channel request; held with its data until granted.
- sample_i  in  NCH*W  channel k sample at bits [k*W +: W].
- lo_i  in  NCH*W  channel k LO at bits [k*W +: W].
- gnt_o  out  NCH  one-hot, combinational; transfer occurs on an edge where req_i[k] and gnt_o[k] are both 1.
- mix_interp_o  out  W  registered operand to MIXER interp_i.
- mix_lo_o  out  W  registered operand to MIXER LO.
- mix_result_i  in  W  MIXER mix_o (combinational from the two operands above).
- res_valid_o  out  1  result valid.
- res_ch_o  out  CW  channel tag of result.
- res_data_o  out  W  captured mixer result.
- res_ready_i  in  1  consumer ready; result transfers on edge with valid and ready.
- busy_o  out  1  op_valid OR res_valid_o.

## Operation
- Two-stage pipeline: stage A (op_valid, op_ch, operands) and stage B (res_valid_o, res_ch_o, res_data_o).
- B free: !res_valid_o OR res_ready_i. A advances: op_valid AND B free. A can load: !op_valid OR A advances.
- Grant: when en_i=1 and A can load, scan channels starting at ptr, wrapping modulo NCH. The first k with req_i[k]=1 gets gnt_o[k]=1. Otherwise gnt_o=0.
- On a grant edge:
  - A loads sample_i/lo_i of k, op_ch=k, op_valid=1.
  - ptr <= (k+1) mod NCH.
- On an edge with A advancing and no grant, op_valid <= 0.
- mix_interp_o/mix_lo_o equal the stage-A operands while op_valid=1. They are forced to 0 while op_valid=0, so the mixer sees zero.
- When A advances, B captures mix_result_i and op_ch, and res_valid_o=1.
- On a transfer edge with no A advance, res_valid_o <= 0.
- Backpressure: with res_valid_o=1 and res_ready_i=0, B holds res_data_o/res_ch_o stable, A holds, and gnt_o=0 whenever op_valid=1.
- ptr is unchanged when no grant occurs. A requester dropping req_i without a grant loses nothing and is simply skipped.
- en_i low mid-stream: no new grants; A and B drain normally. busy_o falls once both are empty.
- Result width: the mixer result passes through unmodified. The scheduler does no arithmetic on data.

## Timing
- Reset (reset_n=0 at an edge) clears op_valid, res_valid_o, res_ch_o, res_data_o, mix_interp_o, mix_lo_o and ptr (channel 0 highest priority).
  - gnt_o is 0 throughout reset.
  - In-flight work is discarded, with no result emitted.
- Latency: grant at edge t gives res_valid_o=1 after edge t+1 when res_ready_i stays high.
- Throughput: one grant and one result per cycle with res_ready_i=1 and requests pending.
- A simultaneous grant and A-advance in one edge is legal and required for full throughput.
- A simultaneous B transfer and B reload is legal.

## Test plan
Bench MIXER model: mix_o = (interp_i*LO)>>14, truncated to W bits.
- Reset: reset_n=0 for 3 cycles with all req_i=1 -> gnt_o=0, res_valid_o=0, mix operands 0, busy_o=0. Released: ch0 granted first.
- Single request: ch2 only, sample 0x4000, LO 0x4000, res_ready_i=1 -> gnt_o=0100 for 1 cycle. res_valid_o 2 edges later with res_ch_o=2 and res_data_o=0x4000, then mix operands return to 0.
- Round robin: all 4 req_i held high, res_ready_i=1 -> grants ch0,1,2,3,0,1... each cycle. Results are back-to-back with tags in the same order, and there are no bubbles.
- Backpressure: ch1 sample 100, LO 300, res_ready_i=0 after the first result -> res_data_o=1 held stable, and gnt_o=0 once A is full. When ready is raised, the next result appears one cycle later and no data is lost or duplicated.
- en_i and reset mid-operation:
  - en_i dropped with ops in A and B -> both drain, no new gnt_o, busy_o falls.
  - reset_n pulsed with A and B full -> no result emitted, ptr back to 0.
- Wrap and skip: ptr=3 with req on ch1 and ch3 -> ch3 granted first, then ch1. Dropping ch1's request before its grant -> ch1 skipped, no spurious result.
